// File: rtl/muldiv_hilo_ctrl_if.sv
// Decode-side handshake and HI/LO control bundle for muldiv_hilo_ctrl.
// The master modport is the decode/pipeline side; the slave modport is the controller.
interface muldiv_hilo_ctrl_if;
  logic       op_valid;
  logic [2:0] op;
  logic       divisor_zero;
  logic       div_done;
  logic       flush;
  logic       stall;
  logic       busy;
  logic       mult_start;
  logic       div_start;
  logic       md_signed;
  logic       hi_write;
  logic       lo_write;
  logic [1:0] hi_select;
  logic [1:0] lo_select;
  logic       div0_flag;

  modport master (
    output op_valid, op, divisor_zero, div_done, flush,
    input  stall, busy, mult_start, div_start, md_signed,
           hi_write, lo_write, hi_select, lo_select, div0_flag
  );

  modport slave (
    input  op_valid, op, divisor_zero, div_done, flush,
    output stall, busy, mult_start, div_start, md_signed,
           hi_write, lo_write, hi_select, lo_select, div0_flag
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO sequencing controller: launches mul/div, drives HI/LO write controls, stalls on hazards.
// Optional macro MULDIV_DIV0_TRAP_EN: trap divide-by-zero in the accept cycle instead of launching.
module muldiv_hilo_ctrl #(
  parameter int unsigned MULT_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_hilo_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [2:0] OP_MULT  = 3'b100;
  localparam logic [2:0] OP_MULTU = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;
  localparam logic [2:0] OP_DIVU  = 3'b111;

  localparam logic [SEL_W-1:0] SEL_HOLD = 2'b00;
  localparam logic [SEL_W-1:0] SEL_REG  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_DIV  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_MUL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             stall_c;
  logic             busy_c;
  logic             mult_start_c;
  logic             div_start_c;
  logic             md_signed_c;
  logic             hi_write_c;
  logic             lo_write_c;
  logic [SEL_W-1:0] hi_select_c;
  logic [SEL_W-1:0] lo_select_c;
  logic             div0_flag_c;

`ifndef MULDIV_DIV0_TRAP_EN
  logic unused_divisor_zero;
  assign unused_divisor_zero = bus.divisor_zero;
`endif

  // State and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and combinational outputs; everything held at 0 while in reset
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_c      = 1'b0;
    busy_c       = 1'b0;
    mult_start_c = 1'b0;
    div_start_c  = 1'b0;
    md_signed_c  = 1'b0;
    hi_write_c   = 1'b0;
    lo_write_c   = 1'b0;
    hi_select_c  = SEL_HOLD;
    lo_select_c  = SEL_HOLD;
    div0_flag_c  = 1'b0;

    if (!rst) begin
      busy_c  = (state_q != S_IDLE);
      stall_c = bus.op_valid && busy_c;

      case (state_q)
        S_IDLE: begin
          // A flush in the same cycle kills the presented op
          if (bus.op_valid && !bus.flush) begin
            case (bus.op)
              OP_MTHI: begin
                hi_write_c  = 1'b1;
                hi_select_c = SEL_REG;
              end
              OP_MTLO: begin
                lo_write_c  = 1'b1;
                lo_select_c = SEL_REG;
              end
              OP_MULT, OP_MULTU: begin
                mult_start_c = 1'b1;
                md_signed_c  = !bus.op[0];
                cnt_d        = CNT_W'(MULT_LAT);
                state_d      = S_MUL;
              end
              OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV0_TRAP_EN
                if (bus.divisor_zero) begin
                  div0_flag_c = 1'b1;
                end else begin
                  div_start_c = 1'b1;
                  md_signed_c = !bus.op[0];
                  state_d     = S_DIV;
                end
`else
                div_start_c = 1'b1;
                md_signed_c = !bus.op[0];
                state_d     = S_DIV;
`endif
              end
              default: ;
            endcase
          end
        end

        S_MUL: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (bus.flush) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (cnt_q == CNT_W'(1)) begin
            hi_write_c  = 1'b1;
            lo_write_c  = 1'b1;
            hi_select_c = SEL_MUL;
            lo_select_c = SEL_MUL;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end
        end

        S_DIV: begin
          if (bus.flush) begin
            state_d = S_IDLE;
          end else if (bus.div_done) begin
            hi_write_c  = 1'b1;
            lo_write_c  = 1'b1;
            hi_select_c = SEL_DIV;
            lo_select_c = SEL_DIV;
            state_d     = S_IDLE;
          end
        end

        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall      = stall_c;
  assign bus.busy       = busy_c;
  assign bus.mult_start = mult_start_c;
  assign bus.div_start  = div_start_c;
  assign bus.md_signed  = md_signed_c;
  assign bus.hi_write   = hi_write_c;
  assign bus.lo_write   = lo_write_c;
  assign bus.hi_select  = hi_select_c;
  assign bus.lo_select  = lo_select_c;
  assign bus.div0_flag  = div0_flag_c;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed self-checking bench for muldiv_hilo_ctrl (MULT_LAT=4).
// Honors MULDIV_DIV0_TRAP_EN for the divide-by-zero case.
module tb_muldiv_hilo_ctrl;

  localparam logic [2:0] MFHI = 3'b000, MFLO = 3'b001, MTHI = 3'b010, MTLO = 3'b011;
  localparam logic [2:0] MULT = 3'b100, MULTU = 3'b101, DIV = 3'b110, DIVU = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl_if bus ();

  muldiv_hilo_ctrl #(.MULT_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Output vector: {stall, busy, mult_start, div_start, md_signed, hi_w, lo_w, hi_sel, lo_sel, div0}
  function automatic logic [11:0] obs();
    return {bus.stall, bus.busy, bus.mult_start, bus.div_start, bus.md_signed,
            bus.hi_write, bus.lo_write, bus.hi_select, bus.lo_select, bus.div0_flag};
  endfunction

  function automatic logic [11:0] ex(input bit st, input bit bs, input bit ms, input bit ds,
                                     input bit sg, input bit hw, input bit lw,
                                     input bit [1:0] hs, input bit [1:0] ls, input bit d0);
    return {st, bs, ms, ds, sg, hw, lw, hs, ls, d0};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Advance one cycle, drive inputs just after the edge, settle before checking
  task automatic cyc(input bit r, input bit v, input logic [2:0] o,
                     input bit dz, input bit dd, input bit fl);
    @(posedge clk);
    #1;
    rst              = r;
    bus.op_valid     = v;
    bus.op           = o;
    bus.divisor_zero = dz;
    bus.div_done     = dd;
    bus.flush        = fl;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, MFHI, 0, 0, 0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.op_valid     = 1'b0;
    bus.op           = MFHI;
    bus.divisor_zero = 1'b0;
    bus.div_done     = 1'b0;
    bus.flush        = 1'b0;

    cyc(1, 0, MFHI, 0, 0, 0);
    chk("reset_outputs", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));
    cyc(1, 0, MFHI, 0, 0, 0);

    // MTHI then MTLO back-to-back
    cyc(0, 1, MTHI, 0, 0, 0);
    chk("mthi", obs(), ex(0,0,0,0,0,1,0,2'b01,2'b00,0));
    cyc(0, 1, MTLO, 0, 0, 0);
    chk("mtlo", obs(), ex(0,0,0,0,0,0,1,2'b00,2'b01,0));
    cyc(0, 1, MFHI, 0, 0, 0);
    chk("mfhi_idle", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));

    // MULT: start at T, busy T+1..T+4, writes at T+4
    cyc(0, 1, MULT, 0, 0, 0);
    chk("mult_start", obs(), ex(0,0,1,0,1,0,0,2'b00,2'b00,0));
    for (int i = 1; i <= 3; i++) begin
      idle_cyc();
      chk("mult_busy", obs(), ex(0,1,0,0,0,0,0,2'b00,2'b00,0));
    end
    idle_cyc();
    chk("mult_write", obs(), ex(0,1,0,0,0,1,1,2'b11,2'b11,0));
    idle_cyc();
    chk("mult_after", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));

    // MULTU with MFLO held from T+1: stall T+1..T+4, accepted T+5
    cyc(0, 1, MULTU, 0, 0, 0);
    chk("multu_start", obs(), ex(0,0,1,0,0,0,0,2'b00,2'b00,0));
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, MFLO, 0, 0, 0);
      chk("mflo_stall", obs(), ex(1,1,0,0,0,0,0,2'b00,2'b00,0));
    end
    cyc(0, 1, MFLO, 0, 0, 0);
    chk("mflo_stall_wr", obs(), ex(1,1,0,0,0,1,1,2'b11,2'b11,0));
    cyc(0, 1, MFLO, 0, 0, 0);
    chk("mflo_accept", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));

    // MULT then DIV held from T+1: div_start at T+5
    cyc(0, 1, MULT, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, DIV, 0, 0, 0);
      chk("div_held_stall", obs() & 12'b1100_0000_0000, 12'b1100_0000_0000);
    end
    cyc(0, 1, DIV, 0, 0, 0);
    chk("div_held_start", obs(), ex(0,0,0,1,1,0,0,2'b00,2'b00,0));
    idle_cyc();
    cyc(0, 0, MFHI, 0, 1, 0);
    chk("div_done_write", obs(), ex(0,1,0,0,0,1,1,2'b10,2'b10,0));

    // DIVU with div_done at accept+7
    cyc(0, 1, DIVU, 0, 0, 0);
    chk("divu_start", obs(), ex(0,0,0,1,0,0,0,2'b00,2'b00,0));
    for (int i = 1; i <= 6; i++) begin
      idle_cyc();
      chk("divu_busy", obs(), ex(0,1,0,0,0,0,0,2'b00,2'b00,0));
    end
    cyc(0, 0, MFHI, 0, 1, 0);
    chk("divu_write", obs(), ex(0,1,0,0,0,1,1,2'b10,2'b10,0));
    cyc(0, 0, MFHI, 0, 1, 0);
    chk("divu_stray_done", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));

    // Stuck divider, flush at accept+3 beating a same-cycle div_done; stray done at +9
    cyc(0, 1, DIV, 0, 0, 0);
    idle_cyc();
    idle_cyc();
    cyc(0, 0, MFHI, 0, 1, 1);
    chk("div_flush", obs(), ex(0,1,0,0,0,0,0,2'b00,2'b00,0));
    idle_cyc();
    chk("div_flush_idle", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));
    for (int i = 5; i <= 8; i++) idle_cyc();
    cyc(0, 0, MFHI, 0, 1, 0);
    chk("div_late_done", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));

    // Flush on the final multiply count suppresses the write
    cyc(0, 1, MULT, 0, 0, 0);
    for (int i = 1; i <= 3; i++) idle_cyc();
    cyc(0, 0, MFHI, 0, 0, 1);
    chk("mult_flush_last", obs(), ex(0,1,0,0,0,0,0,2'b00,2'b00,0));
    idle_cyc();
    chk("mult_flush_idle", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));

    // Flush in IDLE kills the presented op
    cyc(0, 1, MTHI, 0, 0, 1);
    chk("idle_flush_mthi", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));
    cyc(0, 1, MULT, 0, 0, 1);
    chk("idle_flush_mult", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));
    idle_cyc();
    chk("idle_flush_nobusy", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));

    // Divide by zero
    cyc(0, 1, DIV, 1, 0, 0);
`ifdef MULDIV_DIV0_TRAP_EN
    chk("div0_trap", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,1));
    idle_cyc();
    chk("div0_trap_idle", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));
`else
    chk("div0_launch", obs(), ex(0,0,0,1,1,0,0,2'b00,2'b00,0));
    idle_cyc();
    chk("div0_busy", obs(), ex(0,1,0,0,0,0,0,2'b00,2'b00,0));
    cyc(0, 0, MFHI, 0, 1, 0);
    chk("div0_write", obs(), ex(0,1,0,0,0,1,1,2'b10,2'b10,0));
`endif

    // Reset mid-multiply discards the result
    cyc(0, 1, MULTU, 0, 0, 0);
    idle_cyc();
    cyc(1, 0, MFHI, 0, 0, 0);
    chk("rst_mid_mult", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));
    for (int i = 3; i <= 5; i++) begin
      idle_cyc();
      chk("rst_mid_after", obs(), ex(0,0,0,0,0,0,0,2'b00,2'b00,0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
# muldiv_hilo_ctrl

Sequencing controller for the HI/LO register pair and the multiply/divide units feeding it. It accepts decoded HI/LO-class instructions from the decode stage and launches the multiplier or divider. It generates the `hi_write`/`lo_write`/`hi_select`/`lo_select` controls for the HI/LO register block and stalls the pipeline on structural or read-after-write hazards until results land.

## Interface
Parameters:
- `MULT_LAT`, default 4: fixed multiplier latency in cycles, legal range 1..15.

Ports:
- `clk` in 1: clock. One clock domain; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: decode presents an op this cycle.
- `op` in 3: operation code.
  - 000 MFHI, 001 MFLO, 010 MTHI, 011 MTLO.
  - 100 MULT, 101 MULTU, 110 DIV, 111 DIVU.
- `divisor_zero` in 1: divisor operand is zero; sampled with a DIV/DIVU op.
- `div_done` in 1: divider result valid, one-cycle pulse.
- `flush` in 1: kill in-flight operation (exception).
- `stall` out 1: op not accepted this cycle; decode must hold `op`/`op_valid`.
- `busy` out 1: multiply or divide in flight.
- `mult_start` out 1: one-cycle launch pulse to the multiplier.
- `div_start` out 1: one-cycle launch pulse to the divider.
- `md_signed` out 1: signed operation flag; valid with the start pulse.
- `hi_write`, `lo_write` out 1: register write enables.
- `hi_select`, `lo_select` out 2: source select.
  - 00 hold, 01 reg_file, 10 div, 11 mult.
- `div0_flag` out 1: divide-by-zero pulse (only with macro, see Configuration).

## Operation
- FSM states: IDLE, MUL, DIV.
- Accept condition: `op_valid && !stall`.
- `stall = op_valid && busy`. Any op class stalls while busy, including MFHI/MFLO (RAW hazard) and MTHI/MTLO (WAW hazard).
- IDLE handling by op:
  - MTHI: `hi_write=1`, `hi_select=01` in the accept cycle.
  - MTLO: `lo_write=1`, `lo_select=01` in the accept cycle.
  - MFHI/MFLO: no write; accepted with no side effect.
- IDLE + MULT/MULTU accepted:
  - `mult_start=1` in the accept cycle; `md_signed` is `op[0]==0`.
  - Load the 4-bit down-counter with MULT_LAT; go to MUL.
- MUL state:
  - Counter decrements every cycle.
  - In the cycle the counter equals 1, assert `hi_write=lo_write=1` with selects 11, then return to IDLE.
- IDLE + DIV/DIVU accepted: assert `div_start`, go to DIV.
- DIV state:
  - Wait for `div_done`.
  - In the `div_done` cycle, assert both writes with selects 10, then return to IDLE.
  - No timeout.
- `busy` is 1 in MUL and DIV.
- When not writing, selects are 00 and writes are 0.
- `flush` in MUL/DIV:
  - Return to IDLE next cycle; no HI/LO write that cycle.
  - Flush beats a same-cycle `div_done` or final count.
  - A `div_done` arriving after a flush is ignored in IDLE.
- `flush` in IDLE: the op presented that cycle is not accepted; no writes, no starts.
- `div_done` outside DIV: ignored.
- Reset mid-operation: IDLE, counter 0, in-flight result discarded.

## Timing
- Reset values: state IDLE; all outputs 0 (`stall`, `busy`, starts, writes, selects, `div0_flag`, `md_signed`).
- Outputs are combinational from state, counter and inputs. State and counter are registered.
- MULT accepted in cycle T:
  - `busy` is 1 in T+1..T+MULT_LAT.
  - Writes are asserted in cycle T+MULT_LAT; HI/LO are updated at the end of that cycle.
  - A new op is accepted no earlier than T+MULT_LAT+1.
- MFHI in cycle T+MULT_LAT stalls. In T+MULT_LAT+1 it is accepted and sees the new value.
- DIV: writes occur in the same cycle as `div_done`. Accept resumes the following cycle.
- MTHI/MTLO: zero-latency write; HI/LO are updated at the end of the accept cycle.

## Configuration
- `MULDIV_DIV0_TRAP_EN` defined:
  - A DIV/DIVU accepted with `divisor_zero=1` does not pulse `div_start` and stays in IDLE.
  - HI/LO are unchanged; `div0_flag` pulses in the accept cycle.
- Undefined:
  - `divisor_zero` is ignored; the divider is launched normally.
  - `div0_flag` is tied to 0.

## Test plan
- Reset, then MTHI then MTLO back-to-back:
  - Cycle 1: `hi_write=1`, `hi_select=01`. Cycle 2: `lo_write=1`, `lo_select=01`.
  - No stall; `busy=0` throughout.
- MULT with MULT_LAT=4 accepted at T=10:
  - `mult_start` and `md_signed=1` at 10.
  - `busy` at 11–14; both writes with selects 11 at cycle 14 only.
  - MULTU repeat: `md_signed=0`.
- MULT at T=10 then MFLO held from 11:
  - `stall=1` at 11–14; MFLO accepted at 15.
  - A DIV held from 11 gets `div_start` at 15.
- DIVU with `div_done` at accept+7: `div_start` at accept, `busy` for 7 cycles, writes with selects 10 in the `div_done` cycle.
- Divider stops responding: `busy` stays 1 with no write. `flush` at accept+3 gives IDLE next cycle. A stray `div_done` at accept+9 produces no write.
- DIV with `divisor_zero=1`:
  - Macro defined: `div0_flag` for one cycle, no `div_start`, `busy=0`.
  - Macro undefined: `div_start=1` and normal DIV flow.
